// File: rtl/fec_dec0_2d_crc.sv
// Uplink FEC decoder: 2D-parity single-bit correction followed by CRC check.
// Mirror of the downlink CRC-0 / 2D-parity encoder.
module fec_dec0_2d_crc #(
    parameter int ROWS              = 8,
    parameter int COLS              = 8,
    parameter int CRC_W             = 8,
    parameter logic [CRC_W:0] CRC_POLY = 9'h107,
    parameter logic [CRC_W-1:0] CRC_SEED = 8'h00,
    parameter int XOR_OPS_PER_CYCLE = 8,
    parameter int CNT_W             = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ROWS*COLS-1:0]        in_data,
    input  logic [ROWS-1:0]             in_row_par,
    input  logic [COLS-1:0]             in_col_par,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROWS*COLS-CRC_W-1:0]  out_msg,
    output logic [1:0]                  out_status,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            cnt_corr,
    output logic [CNT_W-1:0]            cnt_fail
);

    localparam int N     = ROWS * COLS;
    localparam int MSG_W = N - CRC_W;
    localparam int X     = XOR_OPS_PER_CYCLE;
    localparam int BEATS = MSG_W / X;
    localparam int BW    = $clog2(BEATS + 1);

    localparam logic [CRC_W-1:0] TAPS = CRC_POLY[CRC_W-1:0];
    localparam logic [CNT_W-1:0] CMAX = '1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] S_CRC = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_CORR  = 2'b01;
    localparam logic [1:0] ST_UNC   = 2'b10;
    localparam logic [1:0] ST_CRC   = 2'b11;

    logic [1:0]       state;
    logic [N-1:0]     mat;
    logic [ROWS-1:0]  rpar;
    logic [COLS-1:0]  cpar;
    logic [MSG_W-1:0] msg_sh;
    logic [CRC_W-1:0] crc_reg;
    logic [BW-1:0]    beat;
    logic [1:0]       cls;

    logic [ROWS-1:0]  rsyn;
    logic [COLS-1:0]  csyn;
    logic [N-1:0]     fixed;
    logic [1:0]       cls_n;
    logic [CRC_W-1:0] crc_next;
    logic [X-1:0]     chunk;
    logic [1:0]       st_n;
    logic             last_beat;
    logic             hs;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign hs        = out_valid && out_ready;
    assign last_beat = (beat == BW'(BEATS - 1));

    always_comb begin
        logic colx;
        rsyn = '0;
        csyn = '0;
        for (int r = 0; r < ROWS; r++)
            rsyn[r] = ^mat[COLS*(ROWS-1-r) +: COLS] ^ rpar[r];
        for (int c = 0; c < COLS; c++) begin
            colx = 1'b0;
            for (int r = 0; r < ROWS; r++)
                colx = colx ^ mat[COLS*(ROWS-1-r) + c];
            csyn[c] = colx ^ cpar[c];
        end
    end

    // A single onehot syndrome with the other zero means a parity bit flipped.
    always_comb begin
        fixed = mat;
        cls_n = ST_UNC;
        if (rsyn == '0 && csyn == '0) begin
            cls_n = ST_CLEAN;
        end else if ($onehot(rsyn) && $onehot(csyn)) begin
            cls_n = ST_CORR;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (rsyn[r] && csyn[c])
                        fixed[COLS*(ROWS-1-r) + c] = ~mat[COLS*(ROWS-1-r) + c];
        end else if (($onehot(rsyn) && csyn == '0) ||
                     (rsyn == '0 && $onehot(csyn))) begin
            cls_n = ST_CORR;
        end
    end

    always_comb begin
        logic fb;
        chunk    = msg_sh[MSG_W-1 -: X];
        crc_next = crc_reg;
        for (int i = X - 1; i >= 0; i--) begin
            fb       = crc_next[CRC_W-1] ^ chunk[i];
            crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ (fb ? TAPS : '0);
        end
    end

    always_comb begin
        st_n = cls;
        if (cls == ST_UNC)
            st_n = ST_UNC;
        else if (crc_next != mat[CRC_W-1:0])
            st_n = ST_CRC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mat        <= '0;
            rpar       <= '0;
            cpar       <= '0;
            msg_sh     <= '0;
            crc_reg    <= '0;
            beat       <= '0;
            cls        <= ST_CLEAN;
            out_msg    <= '0;
            out_status <= ST_CLEAN;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mat   <= in_data;
                        rpar  <= in_row_par;
                        cpar  <= in_col_par;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    mat     <= fixed;
                    msg_sh  <= fixed[N-1:CRC_W];
                    cls     <= cls_n;
                    crc_reg <= CRC_SEED;
                    beat    <= '0;
                    state   <= S_CRC;
                end
                S_CRC: begin
                    crc_reg <= crc_next;
                    msg_sh  <= msg_sh << X;
                    beat    <= beat + 1'b1;
                    if (last_beat) begin
                        out_msg    <= mat[N-1:CRC_W];
                        out_status <= st_n;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr <= '0;
            cnt_fail <= '0;
        end else if (cnt_clr) begin
            cnt_corr <= '0;
            cnt_fail <= '0;
        end else if (hs) begin
            if (out_status == ST_CORR && cnt_corr != CMAX)
                cnt_corr <= cnt_corr + 1'b1;
            if (out_status[1] && cnt_fail != CMAX)
                cnt_fail <= cnt_fail + 1'b1;
        end
    end

endmodule

// File: tb/tb_fec_dec0_2d_crc.sv
// Scoreboard bench for fec_dec0_2d_crc; a narrow-counter twin
// instance shares the stimulus to reach counter saturation quickly.
module tb_fec_dec0_2d_crc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_row_par;
    logic [7:0]  in_col_par;
    logic        out_valid;
    logic        out_ready;
    logic [55:0] out_msg;
    logic [1:0]  out_status;
    logic        cnt_clr;
    logic [15:0] cnt_corr;
    logic [15:0] cnt_fail;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [55:0] s_out_msg;
    logic [1:0]  s_out_status;
    logic [2:0]  s_cnt_corr;
    logic [2:0]  s_cnt_fail;

    typedef struct {
        logic [55:0] msg;
        logic [1:0]  st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   e_corr = 0, e_fail = 0, s_corr = 0, s_fail = 0;

    always #5 clk = ~clk;

    fec_dec0_2d_crc dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_row_par(in_row_par), .in_col_par(in_col_par),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_msg(out_msg), .out_status(out_status),
        .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_fail(cnt_fail)
    );

    fec_dec0_2d_crc #(.CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_row_par(in_row_par), .in_col_par(in_col_par),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_msg(s_out_msg), .out_status(s_out_status),
        .cnt_clr(cnt_clr), .cnt_corr(s_cnt_corr), .cnt_fail(s_cnt_fail)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: CRC-8 (x^8+x^2+x+1) over the message, then 2D parity.
    function automatic logic [79:0] enc(input logic [55:0] m);
        logic [7:0]  c;
        logic [63:0] d;
        logic [7:0]  rp;
        logic [7:0]  cp;
        logic        fb;
        c = 8'h00;
        for (int i = 55; i >= 0; i--) begin
            fb = c[7] ^ m[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        d  = {m, c};
        cp = 8'h00;
        for (int r = 0; r < 8; r++) begin
            rp[r] = ^d[8*(7-r) +: 8];
            cp    = cp ^ d[8*(7-r) +: 8];
        end
        return {d, rp, cp};
    endfunction

    task automatic send(input logic [63:0] d, input logic [7:0] rp,
                        input logic [7:0] cp, input logic [55:0] em,
                        input logic [1:0] es);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_data    = d;
        in_row_par = rp;
        in_col_par = cp;
        step();
        in_valid = 1'b0;
        e.msg = em;
        e.st  = es;
        q.push_back(e);
    endtask

    task automatic wait_out(input bit check_lat);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        if (check_lat) chk("latency", 64'(n), 64'd8);
        else if (n >= 30) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic bump(input logic [1:0] st);
        if (st == 2'b01) begin
            if (e_corr < 65535) e_corr++;
            if (s_corr < 7) s_corr++;
        end
        if (st[1]) begin
            if (e_fail < 65535) e_fail++;
            if (s_fail < 7) s_fail++;
        end
    endtask

    task automatic rcv(input bit check_lat);
        exp_t e;
        wait_out(check_lat);
        if (q.size() == 0) begin
            chk("queue_empty", 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            chk("out_msg", 64'(out_msg), 64'(e.msg));
            chk("out_status", 64'(out_status), 64'(e.st));
            chk("twin_msg", 64'(s_out_msg), 64'(e.msg));
            bump(e.st);
        end
        out_ready = 1'b1;
        step();
        chk("ov_drop", 64'(out_valid), 64'd0);
        chk("rdy_back", 64'(in_ready), 64'd1);
        chk("cnt_corr", 64'(cnt_corr), 64'(e_corr));
        chk("cnt_fail", 64'(cnt_fail), 64'(e_fail));
        chk("s_cnt_corr", 64'(s_cnt_corr), 64'(s_corr));
        chk("s_cnt_fail", 64'(s_cnt_fail), 64'(s_fail));
    endtask

    initial begin
        logic [79:0] w;
        logic [55:0] m;
        logic [63:0] d;
        logic [7:0]  rp, cp;
        logic [1:0]  es;
        int          k;
        int          bad;
        exp_t        junk;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_row_par = '0;
        in_col_par = '0;
        out_ready  = 1'b1;
        cnt_clr    = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_msg", 64'(out_msg), 64'd0);
        chk("rst_status", 64'(out_status), 64'd0);
        chk("rst_cnt", {32'(cnt_corr), 32'(cnt_fail)}, 64'd0);
        rst_n = 1'b1;
        step();

        send(64'h0000_0000_0000_0107, 8'hC0, 8'h06, 56'h01, 2'b00);
        rcv(1);
        send(64'h8000_0000_0000_0107, 8'hC0, 8'h06, 56'h01, 2'b01);
        rcv(1);
        send(64'h0000_0000_0000_0107, 8'hC1, 8'h06, 56'h01, 2'b01);
        rcv(1);
        send(64'hC000_0000_0000_0107, 8'hC0, 8'h06,
             56'hC0_0000_0000_0001, 2'b10);
        rcv(1);
        send(64'h0000_0000_0000_0106, 8'h40, 8'h07, 56'h01, 2'b11);
        rcv(1);

        for (int i = 0; i < 12; i++) begin
            m  = {$urandom, $urandom};
            w  = enc(m);
            d  = w[79:16];
            rp = w[15:8];
            cp = w[7:0];
            k  = $urandom_range(0, 80);
            es = 2'b01;
            if (k < 64) d[k] = ~d[k];
            else if (k < 72) rp[k-64] = ~rp[k-64];
            else if (k < 80) cp[k-72] = ~cp[k-72];
            else es = 2'b00;
            send(d, rp, cp, m, es);
            rcv(1);
        end

        out_ready = 1'b0;
        send(64'h0000_0000_0000_0107, 8'hC0, 8'h06, 56'h01, 2'b00);
        wait_out(1);
        bad = 0;
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_0000_0000;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_msg !== 56'h01 ||
                out_status !== 2'b00 || in_ready !== 1'b0) bad++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_stable", 64'(bad), 64'd0);
        rcv(0);

        out_ready = 1'b0;
        send(64'h8000_0000_0000_0107, 8'hC0, 8'h06, 56'h01, 2'b01);
        wait_out(1);
        junk = q.pop_front();
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        step();
        cnt_clr = 1'b0;
        e_corr = 0; e_fail = 0; s_corr = 0; s_fail = 0;
        chk("clr_prio", {32'(cnt_corr), 32'(cnt_fail)}, 64'd0);
        chk("clr_twin", {32'(s_cnt_corr), 32'(s_cnt_fail)}, 64'd0);

        for (int i = 0; i < 9; i++) begin
            m = 56'(i) + 56'h1234;
            w = enc(m);
            d = w[79:16];
            d[8*i % 64] = ~d[8*i % 64];
            send(d, w[15:8], w[7:0], m, 2'b01);
            rcv(1);
        end
        chk("sat_twin", 64'(s_cnt_corr), 64'd7);
        chk("sat_main", 64'(cnt_corr), 64'd9);

        send(64'h0000_0000_0000_0107, 8'hC0, 8'h06, 56'h01, 2'b00);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_twin_rdy", 64'(s_in_ready), 64'd1);
        chk("arst_cnt", {32'(cnt_corr), 32'(cnt_fail)}, 64'd0);
        chk("arst_msg", 64'(out_msg), 64'd0);
        junk = q.pop_front();
        e_corr = 0; e_fail = 0; s_corr = 0; s_fail = 0;
        step();
        rst_n = 1'b1;
        step();
        repeat (12) step();
        chk("arst_idle", {63'd0, s_out_valid | out_valid}, 64'd0);

        send(64'h0000_0000_0000_0106, 8'h40, 8'h07, 56'h01, 2'b11);
        rcv(1);
        chk("twin_status", 64'(s_out_status), 64'(out_status));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fec_dec0_2d_crc.md
Name: fec_dec0_2d_crc

Overview:
- Uplink FEC decoder; mirror of the DL CRC-0 / 2D-parity encoder.
- Accepts one 8x8 codeword matrix plus row and column parity from the UL FIFO read side.
- Corrects any single-bit error using the row/column syndromes, then checks the CRC-8 over the 56 message bits.
- Emits the corrected message with a status code to the RX message formatter.

Parameters:
- ROWS, 8, matrix rows (ENC0_DATA_DEPTH).
- COLS, 8, matrix columns (ENC0_DATA_WIDTH); must equal CRC_W.
- CRC_W, 8, CRC width; the CRC occupies the last row.
- CRC_POLY, 9'h107, generator; the x^CRC_W term is implicit, taps are CRC_POLY[CRC_W-1:0].
- CRC_SEED, 8'h00, CRC register initial value.
- XOR_OPS_PER_CYCLE, 8, message bits folded into the CRC per cycle; must divide (ROWS*COLS-CRC_W).
- CNT_W, 16, width of the error statistics counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  codeword valid
- in_ready  out  1  decoder can accept
- in_data  in  ROWS*COLS  matrix; row r = in_data[COLS*(ROWS-1-r) +: COLS]; row ROWS-1 = CRC
- in_row_par  in  ROWS  bit r = even parity of row r
- in_col_par  in  COLS  bit c = even parity of column c (bit c of every row)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_msg  out  ROWS*COLS-CRC_W  corrected message, in_data[63:8] after correction
- out_status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 CRC fail
- cnt_clr  in  1  synchronous clear of both counters
- cnt_corr  out  CNT_W  saturating count of status 01
- cnt_fail  out  CNT_W  saturating count of status 10 or 11

Behaviour:
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, out_msg=0, out_status=00, counters=0.
- FSM states: IDLE -> CHECK -> CRC -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready (cycle T), register in_data, in_row_par and in_col_par, then go to CHECK. in_ready is 0 in every other state.
- CHECK (T+1), one cycle:
  - rsyn[r] = ^row_r ^ in_row_par[r]; csyn[c] = ^col_c ^ in_col_par[c].
  - Both syndromes zero: clean.
  - rsyn onehot and csyn onehot: flip matrix bit (r,c); corrected.
  - Exactly one syndrome onehot and the other zero: the error is in a parity bit; matrix untouched; corrected.
  - Any other combination: uncorrectable; matrix untouched.
  - Load crc_reg=CRC_SEED and beat counter=0.
- CRC, (ROWS*COLS-CRC_W)/XOR_OPS_PER_CYCLE beats (7 at defaults):
  - Each beat shifts XOR_OPS_PER_CYCLE message bits into crc_reg, MSB first (bit 63 first).
  - Per bit: fb = crc_reg[CRC_W-1]^bit; crc_reg = {crc_reg[CRC_W-2:0],1'b0} ^ (fb ? taps : 0).
  - After the last beat go to DONE.
- DONE: out_valid=1; out_msg and out_status are registered and stable until the handshake.
  - Status priority: uncorrectable(10) > CRC mismatch, crc_reg != corrected row ROWS-1 (11) > corrected(01) > clean(00).
  - out_valid first rises at T+9 (defaults). Latency is fixed and independent of the error type.
  - On out_valid&&out_ready: out_valid drops next cycle and the FSM goes to IDLE. Back-to-back throughput is one codeword per 10 cycles when out_ready is held high.
- Counters:
  - Increment once per DONE handshake, in the handshake cycle.
  - Saturate at 2**CNT_W-1.
  - cnt_clr has priority over a same-cycle increment.
- Async reset mid-operation: the codeword in flight is dropped and all outputs return to their reset values immediately.
- out_ready high while out_valid=0 has no effect. in_valid is ignored outside IDLE.

Test Plan:
- Clean word: in_data=64'h0000_0000_0000_0107, row_par=8'hC0, col_par=8'h06 -> at T+9 out_valid=1, out_msg=56'h01, status=00, counters unchanged.
- Single data-bit error: same word with bit 63 flipped (64'h8000_0000_0000_0107), same parity -> out_msg=56'h01, status=01, cnt_corr=1.
- Parity-only error: clean word with row_par=8'hC1 -> out_msg=56'h01, status=01.
- Double error: bits 63 and 62 flipped -> csyn has 2 bits set, status=10, cnt_fail increments, out_msg=56'hC0_0000_0000_0001 (uncorrected).
- CRC fail: in_data=64'h0000_0000_0000_0106, row_par=8'h40, col_par=8'h07 (parity consistent) -> status=11.
- Backpressure/reset: hold out_ready=0 for 20 cycles -> outputs stable and in_ready=0. Then assert rst_n=0 during CRC on a second word -> out_valid=0 and in_ready=1 immediately, counters=0. Saturation: preload via 65536 corrected words -> cnt_corr stays 16'hFFFF.
